// File: rtl/data_deplexer_en.sv
// Receive-side demultiplexer for a scanned one-hot digit bus: filters each enable slot
// for stability, collects every channel into shadow registers and publishes whole frames only.
module data_deplexer_en #(
    parameter int INPUT_WIDTH = 4,
    parameter int SEL         = 2,
    parameter int CHANNELS    = 3,
    parameter int STABLE      = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [INPUT_WIDTH-1:0]          data_in,
    input  logic [2**SEL-1:0]               data_en,
    output logic [CHANNELS*INPUT_WIDTH-1:0] data_out,
    output logic                            frame_valid,
    output logic                            en_error,
    output logic [CHANNELS-1:0]             chan_seen
);

    localparam int EN_W  = 2**SEL;
    localparam int RUN_W = $clog2(STABLE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [INPUT_WIDTH-1:0]          data_q;
    logic [EN_W-1:0]                 en_q;
    logic [EN_W-1:0]                 en_prev;
    logic [RUN_W-1:0]                run;
    logic [INPUT_WIDTH-1:0]          shadow [CHANNELS];

    logic                            same;
    logic [RUN_W-1:0]                run_cur;
    logic                            accept;
    logic                            onehot;
    logic                            in_range;
    logic                            sel_valid;
    logic                            sel_error;
    logic [CHANNELS-1:0]             seen_next;
    logic                            complete;
    logic [CHANNELS*INPUT_WIDTH-1:0] merged;

    // NOTE: all registered state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            en_q    <= '0;
            en_prev <= '0;
            run     <= '0;
        end else begin
            data_q  <= data_in;
            en_q    <= data_en;
            en_prev <= en_q;
            run     <= run_cur;
        end
    end

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        same    = (en_q == en_prev);
        run_cur = RUN_ONE;
        if (same)
            run_cur = (run == RUN_MAX) ? RUN_MAX : run + RUN_ONE;
        // A saturated run that is still unchanged was already accepted earlier.
        accept    = (run_cur == RUN_MAX) && !(same && (run == RUN_MAX));
        onehot    = (en_q != '0) && ((en_q & (en_q - EN_W'(1))) == '0);
        in_range  = ((en_q >> CHANNELS) == '0);
        sel_valid = accept && onehot && in_range;
        sel_error = accept && (en_q != '0) && !(onehot && in_range);
        seen_next = chan_seen | en_q[CHANNELS-1:0];
        complete  = sel_valid && (&seen_next);
        merged    = '0;
        for (int i = 0; i < CHANNELS; i++)
            merged[i*INPUT_WIDTH +: INPUT_WIDTH] = en_q[i] ? data_q : shadow[i];
    end

    // NOTE: the shadow array is reset explicitly so a frame aborted by reset can never
    // leak stale digits into the next published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++)
                shadow[i] <= '0;
            data_out    <= '0;
            chan_seen   <= '0;
            frame_valid <= 1'b0;
            en_error    <= 1'b0;
        end else begin
            frame_valid <= complete;
            en_error    <= sel_error;
            if (sel_valid) begin
                for (int i = 0; i < CHANNELS; i++)
                    if (en_q[i])
                        shadow[i] <= data_q;
            end
            if (complete) begin
                data_out  <= merged;
                chan_seen <= '0;
            end else if (sel_valid) begin
                chan_seen <= seen_next;
            end else if (sel_error) begin
                chan_seen <= '0;
            end
        end
    end

endmodule

// File: doc/data_deplexer_en.md
Name: data_deplexer_en

Overview:
- Receive-side counterpart of the `data_plexer_en` scan multiplexer.
- Takes the time-multiplexed digit bus (`data_in`) and its one-hot channel enable (`data_en`). Rebuilds the parallel multi-channel data vector.
- Qualifies each channel slot with a stability filter and publishes a complete, coherent frame only after every channel has been captured.
- Sits between a scanned display/link interface and any logic that needs the full parallel word back, e.g. a loopback checker or readback register.

Parameters:
- `INPUT_WIDTH`, 4: bits per channel.
- `SEL`, 2: select width. `data_en` is 2**SEL bits wide.
- `CHANNELS`, 3: number of active channels, 1..2**SEL.
- `STABLE`, 1: consecutive cycles a one-hot `data_en` value must hold before that slot is accepted, 1..15.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_in`  in  INPUT_WIDTH  multiplexed channel data.
- `data_en`  in  2**SEL  one-hot channel enable, active high; bit i means channel i.
- `data_out`  out  CHANNELS*INPUT_WIDTH  last complete frame; channel i at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- `frame_valid`  out  1  one-cycle pulse when `data_out` updates.
- `en_error`  out  1  one-cycle pulse on an illegal enable sample.
- `chan_seen`  out  CHANNELS  channels captured in the current, incomplete frame.

Behaviour:
- Reset (async assert, sync-released use):
  - `data_out`, shadow registers, `chan_seen`, input registers and stability counter go to 0.
  - `frame_valid` and `en_error` go to 0.
  - Reset asserted mid-frame discards the partial frame; `data_out` reads 0.
- Stage 1: `data_in` and `data_en` are registered every cycle into `data_q` and `en_q`.
- Stability counter `run`, saturating at `STABLE`:
  - If `en_q` equals its previous value, `run` increments.
  - Otherwise `run` reloads to 1.
  - A slot is "accepted" exactly once per run, on the cycle `run` reaches `STABLE`. The value written is the `data_q` of that cycle.
- Classification of `en_q` at acceptance:
  - All zero: idle. No write, no error, `chan_seen` unchanged.
  - Exactly one bit i set, i < CHANNELS: write `shadow[i] <= data_q` and set `chan_seen[i]`. A repeat of an already-seen channel overwrites; no error.
  - More than one bit set, or single bit i >= CHANNELS: `en_error` pulses the next cycle. No write, and `chan_seen` clears (frame aborted).
- Frame completion: when an acceptance makes `chan_seen` all ones, on that same edge:
  - `data_out` loads all shadow values, with the newly accepted channel merged in directly, not the stale shadow value.
  - `chan_seen` clears to 0.
  - `frame_valid` is high for exactly the following cycle.
- Latency with `STABLE`=1: the last channel is presented before edge k, registered at edge k, and `data_out`/`frame_valid` update at edge k+1.
- `data_out` holds its value between frames. It never shows a partial frame.
- `frame_valid` and `en_error` are mutually exclusive in any cycle.
- Channel order is free. Completion depends only on the set of channels seen.

Test Plan:
- Reset: drive `rst_n`=0 mid-operation, asynchronously between clock edges → all outputs 0 immediately. After release, the first frame completes normally.
- Scan 0→1→2 repeating, one cycle each, digits 0x0/0x1/0x2, `STABLE`=1 → `data_out`=12'h210 with a `frame_valid` pulse. Pulses recur every 3 cycles.
- Digits change to 0xA/0xB/0xC mid-scan → the next complete frame gives 12'hCBA. The intermediate frame is either 12'h210 or a mix captured strictly per slot; no glitch outside `frame_valid` edges.
- `data_en`=4'b0011 injected after channel 0 → `en_error` pulse, `chan_seen` cleared, no `frame_valid` until a fresh 0,1,2 sequence. `data_en`=4'b1000 gives the same result.
- `STABLE`=3, each channel held 3 cycles then 2 cycles for channel 1 → channel 1 is not accepted and no frame completes. With a 3-cycle hold on channel 1, `frame_valid` follows 1 cycle after its acceptance.
- Out-of-order scan 2,0,2,1 with data 0x7,0x5,0x9,0x6 → `data_out`=12'h965, one `frame_valid` pulse.
